prescaled_counter: RTL and testbench
====================================

Name: prescaled_counter

Overview:
Parametrised free-running / programmable counter with prescaler, four counting modes, a registered terminal-count pulse and a retriggerable LED pulse-stretcher. It is the general-purpose heartbeat/timebase block for emulation builds. It drives status LEDs and provides periodic ticks to other logic from the board system clock.

Parameters:
WIDTH, 8, counter width in bits (2..32)
PRESCALE_WIDTH, 8, prescaler counter and compare width (1..16)
LED_STRETCH, 16, cycles the LED stays lit after each terminal count; 0 = LED mirrors terminal_count

Ports:
system_clock_in  input  1  system clock, all logic on rising edge
system_reset_n  input  1  asynchronous active-low reset
enable  input  1  counting permitted when high
clear  input  1  synchronous clear of counter, prescaler and oneshot-done
load  input  1  synchronous load of counter from load_value
load_value  input  WIDTH  value taken on load
terminal  input  WIDTH  terminal/reload value for RELOAD, ONESHOT and DOWN modes
prescale  input  PRESCALE_WIDTH  tick every prescale+1 enabled cycles
mode  input  2  0 FREE, 1 RELOAD, 2 ONESHOT, 3 DOWN
counter  output  WIDTH  current count
terminal_count  output  1  one-cycle registered pulse on wrap/reload/stop
running  output  1  enable high and not oneshot-done
led  output  1  stretched terminal indication

Behaviour:
- Reset (async, system_reset_n low): counter=0, prescaler=0, oneshot_done=0, terminal_count=0, led=0, stretch counter=0. running is combinational, so it is 0 whenever oneshot_done=1 or enable=0.
- Prescaler: while running, it increments each cycle. When prescaler==prescale, tick=1 and the prescaler returns to 0. prescale=0 gives a tick every cycle. When not running, the prescaler holds.
- Priority each cycle: clear > load > tick.
  - clear: counter=0, prescaler=0, oneshot_done=0, no terminal_count.
  - load: counter=load_value, prescaler=0, oneshot_done=0, no terminal_count.
- On tick, by mode:
  - FREE: counter+1 modulo 2^WIDTH. At all-ones, wraps to 0 and terminal_count fires.
  - RELOAD: if counter>=terminal, counter=0 and fire; else counter+1. Counter above terminal after a load or a terminal change recovers in one tick.
  - ONESHOT: if counter>=terminal, counter holds, oneshot_done=1, fire once; else counter+1. The block stays stopped until clear or load.
  - DOWN: if counter==0, counter=terminal and fire; else counter-1.
- terminal_count is registered and asserted in the cycle where the counter first shows its post-event value (latency 1 from the tick edge). It lasts exactly one cycle and never fires on consecutive cycles unless ticks are consecutive. With terminal=0 and prescale=0 in RELOAD/DOWN, it fires every cycle.
- A mode change mid-count takes effect on the next tick with no reset of the count.
- LED stretcher:
  - When terminal_count=1, the stretch counter loads LED_STRETCH-1 and led=1.
  - Otherwise, while the stretch counter is nonzero, it decrements and led stays 1. When it reaches 0 with no new pulse, led=0 next cycle.
  - A retrigger during stretch restarts the full length.
  - LED_STRETCH=0: led=terminal_count, registered and identical timing.
- Reset asserted mid-operation clears everything immediately. The first tick after deassertion occurs prescale+1 running cycles later.
- All arithmetic is unsigned at WIDTH. No carry out beyond terminal_count.

Decomposition:
- Shared package prescaled_counter_pkg: mode encoding constants (MODE_FREE=0, MODE_RELOAD=1, MODE_ONESHOT=2, MODE_DOWN=3) and the mode typedef.
- One sub-module, led_stretcher: parameter LED_STRETCH; ports system_clock_in, system_reset_n, trigger, led.
- Prescaler and count logic stay in the top module.

Test Plan:
- Reset; WIDTH=8, FREE, prescale=0, enable=1 -> counter 0..255. Counter=0 and terminal_count=1 on cycle 256. led high for exactly 16 cycles.
- RELOAD, terminal=9, prescale=3 -> counter changes every 4 cycles through 0..9. terminal_count fires every 40 cycles, each time coincident with counter=0.
- ONESHOT, terminal=5, prescale=0 -> counts 0..5. Single terminal_count, running=0, counter holds at 5 for 100 cycles. Then load with load_value=2 -> running=1 and counting resumes from 2.
- DOWN, terminal=3, load_value=1 -> sequence 1,0,3,2,1,0,3. terminal_count fires when the counter shows 3.
- clear and load asserted together with a tick, counter=200 -> next cycle counter=0, no terminal_count. enable=0 for 10 cycles -> counter and prescaler frozen, running=0.
- RELOAD, terminal=2, prescale=0, LED_STRETCH=16 -> pulses every 3 cycles retrigger the LED, so led stays continuously high. Drop system_reset_n mid-stretch -> led=0 and counter=0 asynchronously.

Source files
------------

// File: rtl/prescaled_counter_pkg.sv
// Shared definitions for the prescaled counter: counting-mode encoding.
package prescaled_counter_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_DOWN    = 2'd3
    } mode_t;

endpackage

// File: rtl/prescaled_counter_led_stretcher.sv
// Retriggerable pulse stretcher: holds led high for LED_STRETCH cycles after
// each trigger. With LED_STRETCH=0, led is a registered copy of trigger.
module led_stretcher #(
    parameter int LED_STRETCH = 16
) (
    input  logic system_clock_in,
    input  logic system_reset_n,
    input  logic trigger,
    output logic led
);

    logic led_q;

    if (LED_STRETCH == 0) begin : g_mirror
        always_ff @(posedge system_clock_in or negedge system_reset_n) begin
            if (!system_reset_n) begin
                led_q <= 1'b0;
            end else begin
                led_q <= trigger;
            end
        end
    end else begin : g_stretch
        localparam int SW = (LED_STRETCH > 2) ? $clog2(LED_STRETCH) : 1;
        logic [SW-1:0] cnt_q;

        // The trigger cycle itself counts as the first lit cycle, hence LED_STRETCH-1.
        always_ff @(posedge system_clock_in or negedge system_reset_n) begin
            if (!system_reset_n) begin
                cnt_q <= '0;
                led_q <= 1'b0;
            end else if (trigger) begin
                cnt_q <= SW'(LED_STRETCH - 1);
                led_q <= 1'b1;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                led_q <= 1'b1;
            end else begin
                led_q <= 1'b0;
            end
        end
    end

    assign led = led_q;

endmodule

// File: rtl/prescaled_counter.sv
// Prescaled general-purpose counter with four counting modes, a registered
// terminal-count pulse and a stretched LED indication.
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 8,
    parameter int LED_STRETCH    = 16
) (
    input  logic                      system_clock_in,
    input  logic                      system_reset_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic [WIDTH-1:0]          terminal,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [1:0]                mode,
    output logic [WIDTH-1:0]          counter,
    output logic                      terminal_count,
    output logic                      running,
    output logic                      led
);

    logic [WIDTH-1:0]          counter_q, counter_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      done_q, done_d;
    logic                      tc_q, tc_d;
    logic                      tick;
    mode_t                     mode_s;

    assign mode_s  = mode_t'(mode);
    assign running = enable && !done_q;
    assign tick    = running && (presc_q == prescale);

    always_comb begin
        counter_d = counter_q;
        presc_d   = presc_q;
        done_d    = done_q;
        tc_d      = 1'b0;
        if (clear) begin
            counter_d = '0;
            presc_d   = '0;
            done_d    = 1'b0;
        end else if (load) begin
            counter_d = load_value;
            presc_d   = '0;
            done_d    = 1'b0;
        end else begin
            if (running) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                unique case (mode_s)
                    MODE_FREE: begin
                        counter_d = counter_q + 1'b1;
                        tc_d      = (counter_q == '1);
                    end
                    MODE_RELOAD: begin
                        // >= so a counter left above terminal recovers in one tick
                        if (counter_q >= terminal) begin
                            counter_d = '0;
                            tc_d      = 1'b1;
                        end else begin
                            counter_d = counter_q + 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (counter_q >= terminal) begin
                            done_d = 1'b1;
                            tc_d   = 1'b1;
                        end else begin
                            counter_d = counter_q + 1'b1;
                        end
                    end
                    MODE_DOWN: begin
                        if (counter_q == '0) begin
                            counter_d = terminal;
                            tc_d      = 1'b1;
                        end else begin
                            counter_d = counter_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge system_clock_in or negedge system_reset_n) begin
        if (!system_reset_n) begin
            counter_q <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            counter_q <= counter_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            tc_q      <= tc_d;
        end
    end

    // Stretcher is fed the next-state pulse so led rises together with terminal_count.
    led_stretcher #(
        .LED_STRETCH(LED_STRETCH)
    ) u_led_stretcher (
        .system_clock_in(system_clock_in),
        .system_reset_n (system_reset_n),
        .trigger        (tc_d),
        .led            (led)
    );

    assign counter        = counter_q;
    assign terminal_count = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Scoreboard bench for prescaled_counter: directed scenarios followed by
// randomized traffic, checked against a cycle-level reference model.
module tb_prescaled_counter;

    localparam int W   = 8;
    localparam int PW  = 8;
    localparam int LS  = 16;
    localparam int MAX = (1 << W) - 1;
    localparam int PMOD = 1 << PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [W-1:0]  lv = '0, term = '0;
    logic [PW-1:0] psc = '0;
    logic [1:0]    md = 2'd0;
    logic [W-1:0]  cnt_o;
    logic          tc_o, run_o, led_o;

    prescaled_counter #(
        .WIDTH(W), .PRESCALE_WIDTH(PW), .LED_STRETCH(LS)
    ) dut (
        .system_clock_in(clk),
        .system_reset_n (rst_n),
        .enable         (en),
        .clear          (clr),
        .load           (ld),
        .load_value     (lv),
        .terminal       (term),
        .prescale       (psc),
        .mode           (md),
        .counter        (cnt_o),
        .terminal_count (tc_o),
        .running        (run_o),
        .led            (led_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit tc;
        bit run;
        bit led;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int     m_cnt = 0, m_presc = 0;
    bit     m_done = 0;
    longint cyc = 0, last_tc = 0;
    bit     seen_tc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_presc = 0; m_done = 0; seen_tc = 0;
    endtask

    // Advance the model one clock using the inputs currently driven.
    task automatic model_push();
        exp_t x;
        bit   r, t, fire;
        int   mode_i;
        r = en && !m_done;
        t = r && (m_presc == int'(psc));
        fire = 0;
        mode_i = int'(md);
        cyc++;
        if (clr) begin
            m_cnt = 0; m_presc = 0; m_done = 0;
        end else if (ld) begin
            m_cnt = int'(lv); m_presc = 0; m_done = 0;
        end else begin
            if (r) m_presc = t ? 0 : (m_presc + 1) % PMOD;
            if (t) begin
                if (mode_i == 0) begin
                    fire = (m_cnt == MAX);
                    m_cnt = (m_cnt + 1) % (MAX + 1);
                end else if (mode_i == 1) begin
                    if (m_cnt >= int'(term)) begin m_cnt = 0; fire = 1; end
                    else m_cnt++;
                end else if (mode_i == 2) begin
                    if (m_cnt >= int'(term)) begin m_done = 1; fire = 1; end
                    else m_cnt++;
                end else begin
                    if (m_cnt == 0) begin m_cnt = int'(term); fire = 1; end
                    else m_cnt--;
                end
            end
        end
        if (fire) begin
            seen_tc = 1;
            last_tc = cyc;
        end
        x.cnt = m_cnt;
        x.tc  = fire;
        x.run = en && !m_done;
        x.led = seen_tc && ((cyc - last_tc) < LS);
        q.push_back(x);
    endtask

    task automatic step(input bit e, input bit c, input bit l, input int v,
                        input int t, input int p, input int m);
        @(negedge clk);
        en = e; clr = c; ld = l;
        lv = W'(v); term = W'(t); psc = PW'(p); md = 2'(m);
        model_push();
    endtask

    // Asynchronous reset applied between edges, checked immediately.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_counter"}, 32'(cnt_o), 32'd0);
        check({tag, "_tc"},      32'(tc_o),  32'd0);
        check({tag, "_led"},     32'(led_o), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_hold_counter"}, 32'(cnt_o), 32'd0);
        rst_n = 1'b1;
        model_reset();
        model_push();
    endtask

    // Monitor: pops one expectation per clock and compares.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("counter",        32'(cnt_o), 32'(x.cnt));
                check("terminal_count", 32'(tc_o),  32'(x.tc));
                check("running",        32'(run_o), 32'(x.run));
                check("led",            32'(led_o), 32'(x.led));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int r_en, r_term, r_psc, r_mode;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_counter", 32'(cnt_o), 32'd0);
        check("reset_tc",      32'(tc_o),  32'd0);
        check("reset_led",     32'(led_o), 32'd0);
        check("reset_running", 32'(run_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // FREE, prescale 0: full wrap and 16-cycle LED
        repeat (300) step(1, 0, 0, 0, 0, 0, 0);
        // RELOAD terminal 9, prescale 3
        step(1, 1, 0, 0, 9, 3, 1);
        repeat (130) step(1, 0, 0, 0, 9, 3, 1);
        // ONESHOT terminal 5: stops, then load 2 restarts
        step(1, 1, 0, 0, 5, 0, 2);
        repeat (110) step(1, 0, 0, 0, 5, 0, 2);
        step(1, 0, 1, 2, 5, 0, 2);
        repeat (10) step(1, 0, 0, 0, 5, 0, 2);
        // DOWN terminal 3 from 1
        step(1, 0, 1, 1, 3, 0, 3);
        repeat (12) step(1, 0, 0, 0, 3, 0, 3);
        // clear+load together with a tick at counter 200, then disabled
        step(1, 0, 1, 200, 0, 0, 0);
        step(1, 1, 1, 55, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0, 2, 0);
        repeat (10) step(0, 0, 0, 0, 0, 2, 0);
        repeat (5) step(1, 0, 0, 0, 0, 2, 0);
        // FREE wrap boundary via load
        step(1, 0, 1, 254, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0, 0);
        // RELOAD/DOWN with terminal 0: fires every cycle
        repeat (6) step(1, 0, 0, 0, 0, 0, 1);
        repeat (6) step(1, 0, 0, 0, 0, 0, 3);
        // RELOAD terminal 2: continuous LED, then reset mid-stretch
        step(1, 1, 0, 0, 2, 0, 1);
        repeat (40) step(1, 0, 0, 0, 2, 0, 1);
        async_reset("midstretch");
        repeat (10) step(1, 0, 0, 0, 2, 1, 1);

        // Randomized traffic
        r_en = 1; r_term = 7; r_psc = 0; r_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(31) == 0)
                r_term = ($urandom_range(3) == 0) ? int'($urandom_range(MAX)) : int'($urandom_range(12));
            if ($urandom_range(63) == 0)
                r_psc = ($urandom_range(7) == 0) ? int'($urandom_range(20)) : int'($urandom_range(3));
            if ($urandom_range(47) == 0) r_mode = int'($urandom_range(3));
            r_en = ($urandom_range(7) != 0);
            step(r_en, $urandom_range(63) == 0, $urandom_range(47) == 0,
                 int'($urandom_range(MAX)), r_term, r_psc, r_mode);
            if (i == 1500) async_reset("random");
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
